adc_overrange_detect: RTL

Producer of the `adc_overrange` flag consumed by the clip LED stretcher.
- Monitors the raw ADC sample stream and the ADC's hardware OVR pin in the ADC clock domain.
- Declares a clip event after a programmable run of full-scale samples.
- Holds `adc_overrange` high long enough for the slow-clock consumer to sample it reliably.
- Optionally keeps a saturating clip-event counter for the control interface.

---
 rtl/adc_pkg.sv | 16 +
 rtl/adc_overrange_detect_if.sv | 12 +
 rtl/abs_sat.sv | 23 ++
 rtl/adc_overrange_detect.sv | 102 ++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared constants for the ADC overrange detector
// FSM encoding, clip counter width and the default stretch length.
package adc_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  localparam int CLIP_CNT_W = 16;

  // Default stretch is the slow_clock period in adc_clock cycles, rounded up to a power of two.
  localparam int ADC_CLK_HZ          = 122_880_000;
  localparam int SLOW_CLK_HZ         = 100_000;
  localparam int SLOW_PERIOD_CYCLES  = (ADC_CLK_HZ + SLOW_CLK_HZ - 1) / SLOW_CLK_HZ;
  localparam int HOLD_CYCLES_DEFAULT = 1 << $clog2(SLOW_PERIOD_CYCLES);

endpackage

// File: rtl/adc_overrange_detect_if.sv
// rtl/adc_overrange_detect_if.sv - raw ADC sample stream bundle
// The ADC front end is the master; the detector consumes it as slave.
interface adc_overrange_detect_if #(
  parameter int ADC_WIDTH = 16
);
  logic [ADC_WIDTH-1:0] adc_data;
  logic                 adc_valid;
  logic                 adc_ovr_pin;

  modport master (output adc_data, output adc_valid, output adc_ovr_pin);
  modport slave  (input  adc_data, input  adc_valid, input  adc_ovr_pin);
endinterface

// File: rtl/abs_sat.sv
// rtl/abs_sat.sv - combinational saturating absolute value
// Most-negative input saturates to the largest positive magnitude.
module abs_sat #(
  parameter int ADC_WIDTH = 16
) (
  input  logic [ADC_WIDTH-1:0] i_data,
  output logic [ADC_WIDTH-2:0] o_mag
);

  logic [ADC_WIDTH-1:0] w_neg;

  assign w_neg = -i_data;

  always_comb begin
    o_mag = i_data[ADC_WIDTH-2:0];
    if (i_data[ADC_WIDTH-1]) begin
      // only -2^(W-1) still has its sign bit set after negation
      if (w_neg[ADC_WIDTH-1]) o_mag = '1;
      else                    o_mag = w_neg[ADC_WIDTH-2:0];
    end
  end

endmodule

// File: rtl/adc_overrange_detect.sv
// rtl/adc_overrange_detect.sv - run-qualified ADC clip detector with stretched flag
// Optional saturating clip-event counter enabled by ADC_CLIP_COUNT_EN.
module adc_overrange_detect
  import adc_pkg::*;
#(
  parameter int ADC_WIDTH   = 16,
  parameter int RUN_LEN     = 2,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
  input  logic                    adc_clock,
  input  logic                    reset_n,
  adc_overrange_detect_if.slave   adc_in,
  input  logic [ADC_WIDTH-2:0]    threshold,
  input  logic                    clip_count_clear,
  output logic                    adc_overrange,
  output logic [CLIP_CNT_W-1:0]   clip_count
);

  localparam int            TW         = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(HOLD_CYCLES - 1);
  localparam logic [3:0]    RUN_MAX    = 4'(RUN_LEN);

  logic [ADC_WIDTH-2:0] w_mag;
  logic                 r_s1_valid, r_s1_ovr;
  logic [ADC_WIDTH-2:0] r_s1_mag;
  logic                 r_s2_valid, r_s2_ovr, r_s2_over;
  logic [3:0]           r_run, w_run_inc;
  logic                 w_event;
  logic [0:0]           r_state;
  logic [TW-1:0]        r_timer;

  abs_sat #(.ADC_WIDTH(ADC_WIDTH)) u_abs_sat (
    .i_data (adc_in.adc_data),
    .o_mag  (w_mag)
  );

  always_ff @(posedge adc_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_ovr   <= 1'b0;
      r_s1_mag   <= '0;
      r_s2_valid <= 1'b0;
      r_s2_ovr   <= 1'b0;
      r_s2_over  <= 1'b0;
    end else begin
      r_s1_valid <= adc_in.adc_valid;
      if (adc_in.adc_valid) begin
        r_s1_mag <= w_mag;
        r_s1_ovr <= adc_in.adc_ovr_pin;
      end
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_ovr  <= r_s1_ovr;
        r_s2_over <= r_s1_ovr | (r_s1_mag >= threshold);
      end
    end
  end

  // An OVR-flagged sample fires on its own; otherwise the run must reach RUN_LEN.
  assign w_run_inc = (r_run >= RUN_MAX) ? RUN_MAX : r_run + 4'd1;
  assign w_event   = r_s2_valid & r_s2_over & (r_s2_ovr | (w_run_inc == RUN_MAX));

  always_ff @(posedge adc_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_run   <= 4'd0;
      r_state <= ST_IDLE;
      r_timer <= '0;
    end else begin
      if (r_s2_valid) r_run <= r_s2_over ? w_run_inc : 4'd0;
      if (w_event) begin
        r_state <= ST_HOLD;
        r_timer <= TIMER_LOAD;
      end else if (r_state == ST_HOLD) begin
        if (r_timer == '0) r_state <= ST_IDLE;
        else               r_timer <= r_timer - TW'(1);
      end
    end
  end

  assign adc_overrange = (r_state == ST_HOLD);

`ifdef ADC_CLIP_COUNT_EN
  logic [CLIP_CNT_W-1:0] r_clip_count;

  always_ff @(posedge adc_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_clip_count <= '0;
    end else if (clip_count_clear) begin
      r_clip_count <= '0;
    end else if (w_event && (r_state == ST_IDLE) && (r_clip_count != '1)) begin
      r_clip_count <= r_clip_count + CLIP_CNT_W'(1);
    end
  end

  assign clip_count = r_clip_count;
`else
  logic w_unused_clear;
  assign w_unused_clear = clip_count_clear;
  assign clip_count     = '0;
`endif

endmodule
